// File: rtl/div_pkg.sv
// Shared constants for the multi-cycle signed divider.
// Widths, FSM encodings and the most-negative operand value.
package div_pkg;
    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;
endpackage

// File: rtl/seq_divider_if.sv
// Divider request/response bundle between the multdiv path and the divider.
// The master starts a division; the slave returns the results.
interface seq_divider_if;
    import div_pkg::*;

    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic [WIDTH-1:0] data_remainder;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output ctrl_DIV,
        output data_operandA,
        output data_operandB,
        input  data_result,
        input  data_remainder,
        input  data_exception,
        input  data_resultRDY
    );

    modport slave (
        input  ctrl_DIV,
        input  data_operandA,
        input  data_operandB,
        output data_result,
        output data_remainder,
        output data_exception,
        output data_resultRDY
    );
endinterface

// File: rtl/cla_full_adder.sv
// Carry-lookahead adder built from 4-bit lookahead groups.
// W must be a multiple of 4.
module cla_full_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out
);
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c    = '0;
        c[0] = c_in;
        for (int k = 0; k < W / 4; k++) begin
            c[4*k+1] = g[4*k]
                     | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1]
                     | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2]
                     | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k]
                        & c[4*k]);
            c[4*k+4] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1]
                        & g[4*k])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1]
                        & p[4*k] & c[4*k]);
        end
    end

    assign sum   = p ^ c[W-1:0];
    assign c_out = c[W];
endmodule

// File: rtl/div_negate.sv
// Conditional two's-complement negation: ~value + 1 when enabled.
// Used for operand magnitudes and final sign fix-ups.
module div_negate
    import div_pkg::*;
(
    input  logic [WIDTH-1:0] value,
    input  logic             enable,
    output logic [WIDTH-1:0] result
);
    logic unused_cout;

    cla_full_adder #(.W(WIDTH)) u_add (
        .a     (value ^ {WIDTH{enable}}),
        .b     ('0),
        .c_in  (enable),
        .sum   (result),
        .c_out (unused_cout)
    );
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle 32-bit signed divider, one restoring shift-subtract per cycle.
// Fixed latency: ready strobes in the cycle after edge N+33.
module seq_divider
    import div_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    seq_divider_if.slave bus
);
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] a_raw;
    logic             sign_a;
    logic             sign_b;
    logic             dz;
    logic             ovf;

    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] rmd_q;
    logic             exc_q;
    logic             rdy_q;

    logic [WIDTH-1:0] a_abs_in;
    logic [WIDTH-1:0] b_abs_in;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             cout;
    logic             ge;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             unused_rem_msb;

    div_negate u_abs_a (
        .value  (bus.data_operandA),
        .enable (bus.data_operandA[WIDTH-1]),
        .result (a_abs_in)
    );

    div_negate u_abs_b (
        .value  (bus.data_operandB),
        .enable (bus.data_operandB[WIDTH-1]),
        .result (b_abs_in)
    );

    // Shift {rem, quo} left; the remainder MSB falls off the top.
    assign rem_sh         = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign unused_rem_msb = rem[WIDTH];

    cla_full_adder #(.W(WIDTH)) u_trial (
        .a     (rem_sh[WIDTH-1:0]),
        .b     (~b_abs),
        .c_in  (1'b1),
        .sum   (diff),
        .c_out (cout)
    );

    // Fold the 33rd bit into the borrow: exact 33-bit trial subtraction.
    assign ge      = rem_sh[WIDTH] | cout;
    assign rem_nxt = ge ? {~(rem_sh[WIDTH] ^ cout), diff} : rem_sh;

    div_negate u_fix_q (
        .value  (quo),
        .enable (sign_a ^ sign_b),
        .result (q_fix)
    );

    div_negate u_fix_r (
        .value  (rem[WIDTH-1:0]),
        .enable (sign_a),
        .result (r_fix)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            b_abs  <= '0;
            a_raw  <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            dz     <= 1'b0;
            ovf    <= 1'b0;
            res_q  <= '0;
            rmd_q  <= '0;
            exc_q  <= 1'b0;
            rdy_q  <= 1'b0;
        end else if (bus.ctrl_DIV) begin
            state  <= RUN;
            cnt    <= '0;
            rem    <= '0;
            quo    <= a_abs_in;
            b_abs  <= b_abs_in;
            a_raw  <= bus.data_operandA;
            sign_a <= bus.data_operandA[WIDTH-1];
            sign_b <= bus.data_operandB[WIDTH-1];
            dz     <= (bus.data_operandB == '0);
            ovf    <= (bus.data_operandA == INT_MIN)
                    && (bus.data_operandB == '1);
            exc_q  <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            case (state)
                RUN: begin
                    rem <= rem_nxt;
                    quo <= {quo[WIDTH-2:0], ge};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    rdy_q <= 1'b1;
                    exc_q <= dz | ovf;
                    if (dz) begin
                        res_q <= '0;
                        rmd_q <= a_raw;
                    end else if (ovf) begin
                        res_q <= INT_MIN;
                        rmd_q <= '0;
                    end else begin
                        res_q <= q_fix;
                        rmd_q <= r_fix;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_result    = res_q;
    assign bus.data_remainder = rmd_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
endmodule
